// File: rtl/adc_fifo_byte_serializer.sv
// adc_fifo_byte_serializer: pops packed ADC sample words from an FWFT FIFO and returns them one byte per request.
module adc_fifo_byte_serializer #(
  parameter int pWORD_SAMPLES = 4
) (
  input  logic                          clk_usb,
  input  logic                          reset_i,
  input  logic [12*pWORD_SAMPLES-1:0]   word_data,
  input  logic                          word_empty,
  output logic                          word_rd_en,
  input  logic                          byte_req,
  input  logic                          low_res,
  input  logic                          low_res_lsb,
  input  logic                          clear_errors,
  output logic [7:0]                    byte_data,
  output logic                          byte_valid,
  output logic [7:0]                    underflow_count,
  output logic [31:0]                   fifo_read_count,
  output logic                          holding
);
  localparam int W = 12*pWORD_SAMPLES;
  localparam int NF = 3*pWORD_SAMPLES/2;
  localparam int IW = $clog2(NF+1);
  localparam logic [IW-1:0] LAST_F = IW'(NF-1);
  localparam logic [IW-1:0] LAST_L = IW'(pWORD_SAMPLES-1);
  typedef enum logic {EMPTY, LOADED} state_t;
  state_t state, state_n;
  logic [W-1:0] word_q, word_n;
  logic low_q, low_n, lsb_q, lsb_n, pop, uf, last;
  logic [IW-1:0] idx, idx_n, last_new;
  logic [7:0] byte_n;
  // Byte i of a word in the given mode; full-res packs each sample pair into three bytes.
  function automatic logic [7:0] pick(input logic [W-1:0] w, input logic [IW-1:0] i, input logic low, input logic lsb);
    logic [8*NF-1:0] fs, ls;
    logic [11:0] a, b, s;
    fs = '0;
    ls = '0;
    for (int p = 0; p < pWORD_SAMPLES/2; p++) begin
      a = w[24*p +: 12];
      b = w[24*p+12 +: 12];
      fs[24*p +: 24] = {b[7:0], a[3:0], b[11:8], a[11:4]};
    end
    for (int j = 0; j < pWORD_SAMPLES; j++) begin
      s = w[12*j +: 12];
      ls[8*j +: 8] = lsb ? s[7:0] : s[11:4];
    end
    return low ? ls[8*i +: 8] : fs[8*i +: 8];
  endfunction
  assign last = idx == (low_q ? LAST_L : LAST_F);
  assign last_new = low_res ? LAST_L : LAST_F;
  always_comb begin
    state_n = state;
    word_n = word_q;
    low_n = low_q;
    lsb_n = lsb_q;
    idx_n = idx;
    byte_n = byte_data;
    pop = 1'b0;
    uf = 1'b0;
    if (state == EMPTY) begin
      if (!word_empty) begin
        pop = 1'b1;
        word_n = word_data;
        low_n = low_res;
        lsb_n = low_res_lsb;
        idx_n = '0;
        state_n = LOADED;
        if (byte_req) begin
          byte_n = pick(word_data, '0, low_res, low_res_lsb);
          idx_n = last_new == '0 ? '0 : IW'(1);
          state_n = last_new == '0 ? EMPTY : LOADED;
        end
      end else if (byte_req) begin
        uf = 1'b1;
        byte_n = 8'h00;
      end
    end else if (byte_req) begin
      byte_n = pick(word_q, idx, low_q, lsb_q);
      idx_n = last ? '0 : idx + IW'(1);
      state_n = last ? EMPTY : LOADED;
    end
  end
  assign word_rd_en = pop & ~reset_i;
  assign holding = state == LOADED;
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state <= EMPTY;
      word_q <= '0;
      low_q <= 1'b0;
      lsb_q <= 1'b0;
      idx <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      underflow_count <= '0;
      fifo_read_count <= '0;
    end else begin
      state <= state_n;
      word_q <= word_n;
      low_q <= low_n;
      lsb_q <= lsb_n;
      idx <= idx_n;
      byte_data <= byte_n;
      byte_valid <= byte_req;
      fifo_read_count <= fifo_read_count + 32'(byte_req);
      underflow_count <= clear_errors ? {7'b0, uf} :
                         (uf && underflow_count != 8'hff) ? underflow_count + 8'd1 : underflow_count;
    end
  end
endmodule

// File: tb/tb_adc_fifo_byte_serializer.sv
// tb_adc_fifo_byte_serializer: table vectors plus scoreboarded byte stream against a reference model of the serializer.
module tb_adc_fifo_byte_serializer;
  logic clk_usb = 1'b0;
  logic reset_i = 1'b1;
  logic [47:0] word_data = '0;
  logic word_empty = 1'b1;
  logic word_rd_en;
  logic byte_req = 1'b0, low_res = 1'b0, low_res_lsb = 1'b0, clear_errors = 1'b0;
  logic [7:0] byte_data, underflow_count;
  logic byte_valid, holding;
  logic [31:0] fifo_read_count;

  adc_fifo_byte_serializer #(.pWORD_SAMPLES(4)) dut (
    .clk_usb(clk_usb), .reset_i(reset_i), .word_data(word_data), .word_empty(word_empty),
    .word_rd_en(word_rd_en), .byte_req(byte_req), .low_res(low_res), .low_res_lsb(low_res_lsb),
    .clear_errors(clear_errors), .byte_data(byte_data), .byte_valid(byte_valid),
    .underflow_count(underflow_count), .fifo_read_count(fifo_read_count), .holding(holding)
  );

  always #5 clk_usb = ~clk_usb;

  typedef struct {
    logic [47:0] word;
    logic low;
    logic lsb;
    int n;
    logic [47:0] bytes;
  } vec_t;

  int checks = 0, errors = 0, dut_pops = 0;
  logic [47:0] fifo[$];
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic m_empty = 1'b1;
  logic [7:0] exp_uf = '0;
  logic [31:0] exp_rc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    word_empty = fifo.size() == 0;
    word_data = fifo.size() == 0 ? 48'h0 : fifo[0];
  endtask

  // Reference expansion: samples laid out MSB-first as a bit stream, cut into bytes.
  task automatic load();
    logic [47:0] w, st;
    logic [11:0] s;
    w = fifo[0];
    for (int j = 0; j < 4; j++) st[12*(3-j) +: 12] = w[12*j +: 12];
    mq.delete();
    if (low_res)
      for (int j = 0; j < 4; j++) begin
        s = w[12*j +: 12];
        mq.push_back(low_res_lsb ? s[7:0] : s[11:4]);
      end
    else
      for (int k = 0; k < 6; k++) mq.push_back(st[47-8*k -: 8]);
  endtask

  task automatic step(input logic req, input logic clr);
    logic exp_pop, ufe;
    logic [7:0] eb;
    byte_req = req;
    clear_errors = clr;
    exp_pop = 1'b0;
    ufe = 1'b0;
    eb = 8'h00;
    if (reset_i) begin
      mq.delete();
      sb.delete();
      m_empty = 1'b1;
      exp_uf = '0;
      exp_rc = '0;
    end else begin
      if (req) begin
        if (!m_empty) begin
          eb = mq.pop_front();
          m_empty = mq.size() == 0;
        end else if (fifo.size() > 0) begin
          load();
          exp_pop = 1'b1;
          eb = mq.pop_front();
          m_empty = mq.size() == 0;
        end else ufe = 1'b1;
        sb.push_back(eb);
      end else if (m_empty && fifo.size() > 0) begin
        load();
        exp_pop = 1'b1;
        m_empty = 1'b0;
      end
      exp_rc = exp_rc + 32'(req);
      exp_uf = clr ? {7'b0, ufe} : (ufe && exp_uf != 8'hff) ? exp_uf + 8'd1 : exp_uf;
    end
    #4;
    chk("word_rd_en", {31'b0, word_rd_en}, {31'b0, exp_pop});
    if (word_rd_en) dut_pops++;
    @(posedge clk_usb);
    #1;
    if (exp_pop) void'(fifo.pop_front());
    refresh();
    chk("byte_valid", {31'b0, byte_valid}, {31'b0, req & ~reset_i});
    if (byte_valid && sb.size() > 0) chk("byte_data sb", {24'b0, byte_data}, {24'b0, sb.pop_front()});
    @(negedge clk_usb);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset_i = 1'b0;
    chk("reset holding", {31'b0, holding}, 32'd0);
    chk("reset byte_data", {24'b0, byte_data}, 32'd0);
    chk("reset uf_count", {24'b0, underflow_count}, 32'd0);
    chk("reset read_count", fifo_read_count, 32'd0);
  endtask

  task automatic chk_counters(input string name);
    chk({name, " uf_count"}, {24'b0, underflow_count}, {24'b0, exp_uf});
    chk({name, " read_count"}, fifo_read_count, exp_rc);
  endtask

  vec_t tbl[5];
  int p0;

  initial begin
    tbl[0] = '{48'h123456789ABC, 1'b0, 1'b0, 6, 48'hABC789456123};
    tbl[1] = '{48'h123456789ABC, 1'b1, 1'b0, 4, 48'hAB7845120000};
    tbl[2] = '{48'h123456789ABC, 1'b1, 1'b1, 4, 48'hBC8956230000};
    tbl[3] = '{48'h000FFFF000FF, 1'b0, 1'b0, 6, 48'h0FFF00FFF000};
    tbl[4] = '{48'h000FFFF000FF, 1'b1, 1'b1, 4, 48'hFF00FF000000};
    @(negedge clk_usb);
    do_reset();
    for (int v = 0; v < 5; v++) begin
      low_res = tbl[v].low;
      low_res_lsb = tbl[v].lsb;
      p0 = dut_pops;
      fifo.push_back(tbl[v].word);
      refresh();
      step(1'b0, 1'b0);
      chk("prefetch holding", {31'b0, holding}, 32'd1);
      for (int k = 0; k < tbl[v].n; k++) begin
        step(1'b1, 1'b0);
        chk($sformatf("vec%0d byte%0d", v, k), {24'b0, byte_data}, {24'b0, tbl[v].bytes[47-8*k -: 8]});
      end
      chk("holding after last", {31'b0, holding}, 32'd0);
      chk("pops per word", dut_pops - p0, 32'd1);
      step(1'b0, 1'b0);
    end
    chk_counters("table");
    // Mode change mid-word only affects the next word
    low_res = 1'b0;
    low_res_lsb = 1'b0;
    fifo.push_back(48'h123456789ABC);
    fifo.push_back(48'hFEDCBA987654);
    refresh();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    low_res = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    chk("toggle last full byte", {24'b0, byte_data}, 32'h23);
    step(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    chk("toggle next word low", {24'b0, byte_data}, 32'hFE);
    chk("toggle holding", {31'b0, holding}, 32'd0);
    // Two queued words served by 12 back-to-back requests
    low_res = 1'b0;
    fifo.push_back(48'h123456789ABC);
    fifo.push_back(48'hFEDCBA987654);
    refresh();
    step(1'b0, 1'b0);
    p0 = dut_pops;
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
    chk("b2b last byte", {24'b0, byte_data}, 32'hED);
    chk("b2b pops", dut_pops - p0, 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("clear with underflow", {24'b0, underflow_count}, 32'd1);
    step(1'b0, 1'b1);
    chk("clear alone", {24'b0, underflow_count}, 32'd0);
    chk_counters("b2b");
    // Saturating underflow with an empty FIFO
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0);
    chk("uf saturate", {24'b0, underflow_count}, 32'd255);
    chk("uf read_count", fifo_read_count, 32'd300);
    chk("uf byte", {24'b0, byte_data}, 32'd0);
    chk_counters("underflow");
    // Reset in the middle of a word discards the held bytes
    do_reset();
    fifo.push_back(48'h123456789ABC);
    fifo.push_back(48'hFEDCBA987654);
    refresh();
    step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    chk("pre-reset byte3", {24'b0, byte_data}, 32'h89);
    do_reset();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("post-reset byte0", {24'b0, byte_data}, 32'h65);
    step(1'b1, 1'b0);
    chk("post-reset byte1", {24'b0, byte_data}, 32'h49);
    chk_counters("post-reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
